// File: rtl/frame_buf_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter and its surroundings: display
// reader, processing engine and the single-port frame RAM.
interface frame_buf_arbiter_if #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int SCW = 16
) ();
    logic          disp_en;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          frame_start;
    logic          pe_req;
    logic          pe_we;
    logic [AW-1:0] pe_addr;
    logic [DW-1:0] pe_wdata;
    logic          pe_gnt;
    logic          pe_rvalid;
    logic [DW-1:0] pe_rdata;
    logic          swap_req;
    logic          swap_pending;
    logic          front_bank;
    logic [SCW-1:0] pe_stall_cnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  disp_en, disp_addr, frame_start, pe_req, pe_we, pe_addr, pe_wdata,
               swap_req, mem_rdata,
        output disp_valid, disp_data, pe_gnt, pe_rvalid, pe_rdata, swap_pending,
               front_bank, pe_stall_cnt, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / RAM side
    modport master (
        output disp_en, disp_addr, frame_start, pe_req, pe_we, pe_addr, pe_wdata,
               swap_req, mem_rdata,
        input  disp_valid, disp_data, pe_gnt, pe_rvalid, pe_rdata, swap_pending,
               front_bank, pe_stall_cnt, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/frame_buf_arbiter.sv
// Ping-pong frame-buffer arbiter: display owns the front bank with absolute
// priority, the engine uses the back bank in idle cycles, banks swap at frame start.
module frame_buf_arbiter #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int SCW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    frame_buf_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_SWAP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           front_bank_q;
    logic           swap_pending_q;
    logic           disp_rd_q, pe_rd_q;
    logic           disp_valid_q, pe_rvalid_q;
    logic [DW-1:0]  disp_data_q, pe_rdata_q;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           pe_gnt_s;
    logic           mem_en_s, mem_we_s;
    logic [AW:0]    mem_addr_s;
    logic [DW-1:0]  mem_wdata_s;

    // Engine grant: only in cycles the display and the bank swap leave free
    always_comb begin
        pe_gnt_s = bus.pe_req & ~bus.disp_en & (state_q != ST_SWAP) & ~reset;
    end

    // RAM port mux
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        if (bus.disp_en) begin
            mem_en_s   = 1'b1;
            mem_addr_s = {front_bank_q, bus.disp_addr};
        end else if (pe_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = bus.pe_we;
            mem_addr_s  = {~front_bank_q, bus.pe_addr};
            mem_wdata_s = bus.pe_wdata;
        end else begin
            mem_en_s = 1'b0;
            mem_we_s = 1'b0;
        end
    end

    // Swap FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  state_d = bus.swap_req    ? ST_PEND : ST_RUN;
            ST_PEND: state_d = bus.frame_start ? ST_SWAP : ST_PEND;
            ST_SWAP: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Stall counter saturates instead of wrapping
    always_comb begin
        if (bus.pe_req && !pe_gnt_s && (stall_cnt_q != {SCW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(SCW-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Swap FSM state and its registered outputs; bank flips as SWAP ends
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            swap_pending_q <= 1'b0;
            front_bank_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            swap_pending_q <= (state_d != ST_RUN);
            front_bank_q   <= front_bank_q ^ (state_q == ST_SWAP);
        end
    end

    // Two-stage read pipelines; reset drops reads still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_rd_q    <= 1'b0;
            pe_rd_q      <= 1'b0;
            disp_valid_q <= 1'b0;
            pe_rvalid_q  <= 1'b0;
            disp_data_q  <= '0;
            pe_rdata_q   <= '0;
        end else begin
            disp_rd_q    <= bus.disp_en;
            pe_rd_q      <= pe_gnt_s & ~bus.pe_we;
            disp_valid_q <= disp_rd_q;
            pe_rvalid_q  <= pe_rd_q;
            if (disp_rd_q) begin
                disp_data_q <= bus.mem_rdata;
            end
            if (pe_rd_q) begin
                pe_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Engine stall statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pe_gnt       = pe_gnt_s;
    assign bus.mem_en       = mem_en_s;
    assign bus.mem_we       = mem_we_s;
    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_wdata    = mem_wdata_s;
    assign bus.disp_valid   = disp_valid_q;
    assign bus.disp_data    = disp_data_q;
    assign bus.pe_rvalid    = pe_rvalid_q;
    assign bus.pe_rdata     = pe_rdata_q;
    assign bus.swap_pending = swap_pending_q;
    assign bus.front_bank   = front_bank_q;
    assign bus.pe_stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Directed bench for frame_buf_arbiter: stimulus pushes expected read data into
// queues, a monitor pops them when the valid pulses appear.
module tb_frame_buf_arbiter;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t dq[$];
    exp_t pq[$];
    logic [7:0] wmem [int];

    frame_buf_arbiter_if #(.AW(16), .DW(8), .SCW(16)) bus ();

    frame_buf_arbiter #(.AW(16), .DW(8), .SCW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Initial RAM image; anything else reads 0 until written
    function automatic logic [7:0] ram_init(input logic [16:0] a);
        case (a)
            17'h00102: ram_init = 8'hA5;
            17'h10102: ram_init = 8'h5A;
            17'h00010: ram_init = 8'h77;
            default:   ram_init = 8'h00;
        endcase
    endfunction

    // RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                wmem[int'(bus.mem_addr)] = bus.mem_wdata;
            end else if (wmem.exists(int'(bus.mem_addr))) begin
                bus.mem_rdata <= wmem[int'(bus.mem_addr)];
            end else begin
                bus.mem_rdata <= ram_init(bus.mem_addr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_disp(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 2;
        dq.push_back(e);
    endtask

    task automatic push_pe(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 2;
        pq.push_back(e);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.disp_valid) begin
                if (dq.size() == 0) begin
                    check("disp_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = dq.pop_front();
                    check("disp_data", 32'(bus.disp_data), 32'(e.data));
                    check("disp_latency", 32'(cyc), 32'(e.due));
                end
            end
            if (bus.pe_rvalid) begin
                if (pq.size() == 0) begin
                    check("pe_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = pq.pop_front();
                    check("pe_rdata", 32'(bus.pe_rdata), 32'(e.data));
                    check("pe_latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.disp_en     = 1'b0;
        bus.disp_addr   = 16'h0000;
        bus.frame_start = 1'b0;
        bus.pe_req      = 1'b0;
        bus.pe_we       = 1'b0;
        bus.pe_addr     = 16'h0000;
        bus.pe_wdata    = 8'h00;
        bus.swap_req    = 1'b0;
        bus.mem_rdata   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_front_bank", 32'(bus.front_bank), 32'd0);
        check("rst_swap_pending", 32'(bus.swap_pending), 32'd0);
        check("rst_stall_cnt", 32'(bus.pe_stall_cnt), 32'd0);
        check("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
        check("rst_pe_rvalid", 32'(bus.pe_rvalid), 32'd0);
        check("rst_disp_data", 32'(bus.disp_data), 32'd0);
        check("rst_pe_rdata", 32'(bus.pe_rdata), 32'd0);

        // Display read from bank 0
        @(negedge clk);
        bus.disp_en = 1'b1; bus.disp_addr = 16'h0102;
        #1;
        check("disp_mem_en", 32'(bus.mem_en), 32'd1);
        check("disp_mem_we", 32'(bus.mem_we), 32'd0);
        check("disp_mem_addr", 32'(bus.mem_addr), 32'h00102);
        push_disp(8'hA5);
        @(negedge clk);
        bus.disp_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("disp_valid_pulse", 32'(bus.disp_valid), 32'd0);
        check("disp_data_hold", 32'(bus.disp_data), 32'hA5);

        // Engine write stalled behind three display reads
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.pe_req = 1'b1; bus.pe_we = 1'b1; bus.pe_addr = 16'h0010; bus.pe_wdata = 8'h3C;
            bus.disp_en = 1'b1; bus.disp_addr = 16'h0102;
            #1;
            check("stall_pe_gnt", 32'(bus.pe_gnt), 32'd0);
            check("stall_mem_addr", 32'(bus.mem_addr), 32'h00102);
            push_disp(8'hA5);
        end
        @(negedge clk);
        bus.disp_en = 1'b0;
        #1;
        check("wr_pe_gnt", 32'(bus.pe_gnt), 32'd1);
        check("wr_mem_we", 32'(bus.mem_we), 32'd1);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'h10010);
        check("wr_mem_wdata", 32'(bus.mem_wdata), 32'h3C);
        check("wr_stall_cnt", 32'(bus.pe_stall_cnt), 32'd3);
        @(negedge clk);
        bus.pe_we = 1'b0;
        #1;
        check("rd_pe_gnt", 32'(bus.pe_gnt), 32'd1);
        check("rd_mem_we", 32'(bus.mem_we), 32'd0);
        check("rd_mem_addr", 32'(bus.mem_addr), 32'h10010);
        push_pe(8'h3C);
        @(negedge clk);
        bus.pe_req = 1'b0;
        repeat (3) @(negedge clk);

        // swap_req, then frame_start ten cycles later
        bus.swap_req = 1'b1;
        #1;
        check("sw_pending_before", 32'(bus.swap_pending), 32'd0);
        @(negedge clk);
        bus.swap_req = 1'b0;
        #1;
        check("sw_pending_set", 32'(bus.swap_pending), 32'd1);
        check("sw_front_old", 32'(bus.front_bank), 32'd0);
        repeat (9) @(negedge clk);
        bus.frame_start = 1'b1;
        #1;
        check("sw_pending_hold", 32'(bus.swap_pending), 32'd1);
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.pe_req = 1'b1; bus.pe_we = 1'b0; bus.pe_addr = 16'h0010;
        #1;
        check("sw_cycle_pe_gnt", 32'(bus.pe_gnt), 32'd0);
        check("sw_cycle_pending", 32'(bus.swap_pending), 32'd1);
        check("sw_cycle_front", 32'(bus.front_bank), 32'd0);
        @(negedge clk);
        bus.disp_en = 1'b1; bus.disp_addr = 16'h0102;
        #1;
        check("sw_front_new", 32'(bus.front_bank), 32'd1);
        check("sw_pending_clr", 32'(bus.swap_pending), 32'd0);
        check("sw_disp_mem_addr", 32'(bus.mem_addr), 32'h10102);
        push_disp(8'h5A);
        @(negedge clk);
        bus.disp_en = 1'b0;
        #1;
        check("sw_pe_gnt", 32'(bus.pe_gnt), 32'd1);
        check("sw_pe_mem_addr", 32'(bus.mem_addr), 32'h00010);
        check("sw_stall_cnt", 32'(bus.pe_stall_cnt), 32'd5);
        push_pe(8'h77);
        @(negedge clk);
        bus.pe_req = 1'b0;
        repeat (3) @(negedge clk);

        // swap_req together with frame_start only arms the swap
        bus.swap_req = 1'b1; bus.frame_start = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0; bus.frame_start = 1'b0;
        #1;
        check("co_pending", 32'(bus.swap_pending), 32'd1);
        check("co_front_kept", 32'(bus.front_bank), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("co_front_still", 32'(bus.front_bank), 32'd1);
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.disp_en = 1'b1; bus.disp_addr = 16'h0102;
        #1;
        check("co_swap_disp_addr", 32'(bus.mem_addr), 32'h10102);
        push_disp(8'h5A);
        @(negedge clk);
        #1;
        check("co_front_back", 32'(bus.front_bank), 32'd0);
        check("co_pending_clr", 32'(bus.swap_pending), 32'd0);
        check("co_disp_addr_new", 32'(bus.mem_addr), 32'h00102);
        push_disp(8'hA5);
        @(negedge clk);
        bus.disp_en = 1'b0;
        repeat (3) @(negedge clk);

        // Engine read followed immediately by reset: its response must vanish
        bus.swap_req = 1'b1;
        bus.pe_req = 1'b1; bus.pe_we = 1'b0; bus.pe_addr = 16'h0010;
        #1;
        check("rr_pe_gnt", 32'(bus.pe_gnt), 32'd1);
        check("rr_mem_addr", 32'(bus.mem_addr), 32'h10010);
        @(negedge clk);
        bus.swap_req = 1'b0;
        reset = 1'b1;
        #1;
        check("rr_gnt_in_reset", 32'(bus.pe_gnt), 32'd0);
        check("rr_mem_en_in_reset", 32'(bus.mem_en), 32'd0);
        check("rr_pending_before", 32'(bus.swap_pending), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.pe_req = 1'b0;
        #1;
        check("rr_pe_rvalid", 32'(bus.pe_rvalid), 32'd0);
        check("rr_front_bank", 32'(bus.front_bank), 32'd0);
        check("rr_swap_pending", 32'(bus.swap_pending), 32'd0);
        check("rr_stall_cnt", 32'(bus.pe_stall_cnt), 32'd0);
        check("rr_pe_rdata", 32'(bus.pe_rdata), 32'd0);
        check("rr_disp_data", 32'(bus.disp_data), 32'd0);
        repeat (4) @(negedge clk);

        // Stall counter saturation
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            bus.pe_req = 1'b1; bus.pe_we = 1'b0; bus.pe_addr = 16'h0020;
            bus.disp_en = 1'b1; bus.disp_addr = 16'h0102;
            push_disp(8'hA5);
        end
        @(negedge clk);
        #1;
        check("sat_fffe", 32'(bus.pe_stall_cnt), 32'h0000FFFE);
        push_disp(8'hA5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_disp(8'hA5);
        end
        @(negedge clk);
        bus.disp_en = 1'b0; bus.pe_req = 1'b0;
        #1;
        check("sat_ffff", 32'(bus.pe_stall_cnt), 32'h0000FFFF);
        @(negedge clk);
        bus.pe_req = 1'b1; bus.disp_en = 1'b1;
        push_disp(8'hA5);
        @(negedge clk);
        bus.pe_req = 1'b0; bus.disp_en = 1'b0;
        #1;
        check("sat_no_wrap", 32'(bus.pe_stall_cnt), 32'h0000FFFF);
        repeat (4) @(negedge clk);
        #1;
        check("disp_queue_drained", 32'(dq.size()), 32'd0);
        check("pe_queue_drained", 32'(pq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_buf_arbiter.md
Name: frame_buf_arbiter

Overview:
- Arbitrates one single-port 128K x 8 frame-buffer RAM, split into two 64K banks, between two requesters: the VGA display reader and the image-processing engine.
- The display reads the front bank with absolute priority. The engine reads and writes the back bank in all remaining cycles.
- Sits between the display timing block, the processing engine and the block RAM.
- Handles the ping-pong bank swap, synchronised to the frame boundary.

Parameters:
- AW, 16, per-bank pixel address width (256x256 image).
- DW, 8, pixel data width.
- SCW, 16, width of the saturating engine-stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- disp_en  in  1  display read request this cycle
- disp_addr  in  AW  display pixel address
- disp_valid  out  1  display read data valid
- disp_data  out  DW  display read data
- frame_start  in  1  single-cycle pulse at start of vertical blanking
- pe_req  in  1  engine access request
- pe_we  in  1  engine write (1) / read (0)
- pe_addr  in  AW  engine pixel address
- pe_wdata  in  DW  engine write data
- pe_gnt  out  1  engine access accepted this cycle
- pe_rvalid  out  1  engine read data valid
- pe_rdata  out  DW  engine read data
- swap_req  in  1  single-cycle pulse: engine finished back bank
- swap_pending  out  1  swap requested, not yet performed
- front_bank  out  1  bank currently displayed
- pe_stall_cnt  out  SCW  cycles with pe_req high and pe_gnt low
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW+1  RAM address {bank, pixel address}
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after a read enable

Behaviour:
- Reset is synchronous, active-high on clk. On reset:
  - front_bank=0, FSM=RUN.
  - disp_valid=0, pe_rvalid=0, disp_data=0, pe_rdata=0.
  - pe_stall_cnt=0, swap_pending=0.
  - In-flight reads are discarded; no valid pulse may appear after reset for them.
- Combinational grant logic:
  - disp_en=1: mem_en=1, mem_we=0, mem_addr={front_bank, disp_addr}.
  - Else if pe_gnt=1: mem_en=1, mem_we=pe_we, mem_addr={~front_bank, pe_addr}, mem_wdata=pe_wdata.
  - Else mem_en=0, mem_we=0.
  - pe_gnt = pe_req & ~disp_en & (state!=SWAP) & ~reset.
- Read latency:
  - A display read granted in cycle N gives disp_valid=1 in cycle N+2. disp_data is registered from mem_rdata at the end of N+1.
  - An engine read granted in cycle N gives pe_rvalid=1 in cycle N+2, with pe_rdata handled the same way.
  - Valid flags are single-cycle pulses. Both read pipelines are independent and fully pipelined, one access per cycle.
  - Data registers hold their last value when not valid.
- Writes: committed in the grant cycle; no response is generated. The engine holds pe_req, pe_we, pe_addr and pe_wdata stable until pe_gnt=1.
- Swap FSM:
  - RUN: swap_req=1 -> PEND. frame_start is ignored in RUN.
  - PEND: swap_pending=1. swap_req is ignored. frame_start=1 -> SWAP.
  - SWAP: lasts one cycle. front_bank toggles at the end of the cycle, pe_gnt is forced 0, swap_pending stays 1. Then -> RUN.
  - swap_req and frame_start in the same cycle in RUN: go to PEND only. The swap happens at the next frame_start.
  - A display read in the SWAP cycle uses the old front_bank. A display read in the following cycle uses the new front_bank.
- pe_stall_cnt increments each cycle with pe_req=1 and pe_gnt=0. It saturates at 2^SCW-1, does not wrap, and is cleared only by reset.
- Addresses pass through unmodified. There is no bounds checking; the full 2^AW range is legal.

Test Plan:
- Reset, then a display read with disp_en=1, disp_addr=0x0102 in cycle N, with RAM bank 0 holding 0xA5 at that address -> mem_addr=0x00102, disp_valid=1 and disp_data=0xA5 at N+2.
- pe_req=1, pe_we=1, pe_addr=0x0010, wdata=0x3C, with disp_en high 3 cycles then low -> pe_gnt=0 for 3 cycles; write appears at mem_addr=0x10010 on the 4th cycle; pe_stall_cnt=3. An engine read of 0x0010 then returns pe_rvalid=1, pe_rdata=0x3C two cycles after grant.
- swap_req pulse, then frame_start 10 cycles later -> swap_pending=1 from the cycle after swap_req; SWAP cycle has pe_gnt=0 with pe_req held; front_bank=1 afterwards. A display read of 0x0102 then drives mem_addr=0x10102 and an engine access drives bank 0.
- swap_req and frame_start in the same cycle -> no toggle; front_bank toggles only after the next frame_start pulse.
- Engine read granted, then reset asserted in the next cycle -> pe_rvalid stays 0. front_bank=0, swap_pending=0 and pe_stall_cnt=0 after reset.
- Force pe_stall_cnt to 0xFFFE and hold pe_req with disp_en=1 for 5 cycles -> counter reads 0xFFFF and stays there.
